// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   MEM stage of the pipelined Harvard CPU, sitting between EX and WB.
//   One EX result is accepted per valid/ready handshake. Loads and stores
//   drive the data memory port for MEM_LAT cycles. Non-memory results are
//   passed straight through. The payload is then offered to WB on a
//   valid/ready handshake.
//
//   Every memory-control output comes straight from a flop. The data memory
//   write path is level-sensitive, so a combinational glitch on mem_write
//   could corrupt memory.
//
// Parameters
//   A_BITS   data address width      (default `A_BITS)
//   D_BITS   data word width         (default `D_BITS)
//   R_BITS   register index width    (default 3)
//   MEM_LAT  access cycles per load/store, 1..15
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   ex_valid/ex_ready              EX handshake
//   ex_is_load, ex_is_store        operation kind (both set = store + error)
//   ex_addr, ex_wdata, ex_result   address, store data, ALU result
//   ex_rd, ex_rd_we                destination register and its write enable
//   mem_write, mem_read            data memory strobes (registered)
//   mem_address, mem_data_in       data memory address / write data (registered)
//   mem_data_out                   data memory read data
//   wb_valid/wb_ready              WB handshake
//   wb_data, wb_rd, wb_we          WB payload
//   op_err                         sticky illegal-operation flag
//
// Optional feature (macro MEM_BOUNDS_EN)
//   When defined, a load/store with ex_addr >= `MEMSIZE is not issued to
//   memory. It completes immediately with wb_data=0 and wb_we=0, and it sets
//   op_err.
// -----------------------------------------------------------------------------
`ifndef A_BITS
`define A_BITS 8
`endif
`ifndef D_BITS
`define D_BITS 8
`endif
`ifndef MEMSIZE
`define MEMSIZE 128
`endif

module mem_access_stage #(
  parameter int A_BITS  = `A_BITS,
  parameter int D_BITS  = `D_BITS,
  parameter int R_BITS  = 3,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [A_BITS-1:0] ex_addr,
  input  logic [D_BITS-1:0] ex_wdata,
  input  logic [D_BITS-1:0] ex_result,
  input  logic [R_BITS-1:0] ex_rd,
  input  logic              ex_rd_we,
  output logic              mem_write,
  output logic              mem_read,
  output logic [A_BITS-1:0] mem_address,
  output logic [D_BITS-1:0] mem_data_in,
  input  logic [D_BITS-1:0] mem_data_out,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [D_BITS-1:0] wb_data,
  output logic [R_BITS-1:0] wb_rd,
  output logic              wb_we,
  output logic              op_err
);

  localparam int CW = 4;  // MEM_LAT-1 fits for the legal range 1..15

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  // WB-bound payload
  typedef struct packed {
    logic [D_BITS-1:0] data;
    logic [R_BITS-1:0] rd;
    logic              we;
  } wb_pay_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              ld_q, ld_nx;         // the access in flight is a load
  logic              mem_write_nx, mem_read_nx;
  logic [A_BITS-1:0] addr_nx;
  logic [D_BITS-1:0] wdata_nx;
  wb_pay_t           pay_q, pay_nx;
  logic              wb_valid_nx, err_nx;

  logic accept, mem_op, is_store, oob;

  assign ex_ready = (state == IDLE) | ((state == HOLD) & wb_ready);
  assign accept   = ex_valid & ex_ready;
  assign mem_op   = ex_is_load | ex_is_store;
  // A load+store combination is executed as a store.
  assign is_store = ex_is_store;

`ifdef MEM_BOUNDS_EN
  localparam longint unsigned MEM_LIMIT = `MEMSIZE;
  assign oob = mem_op & (64'(ex_addr) >= MEM_LIMIT);
`else
  assign oob = 1'b0;
`endif

  assign wb_data = pay_q.data;
  assign wb_rd   = pay_q.rd;
  assign wb_we   = pay_q.we;

  // Next-state / next-output logic. Every output is registered below, so
  // nothing combinational reaches the memory port.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    ld_nx        = ld_q;
    mem_write_nx = mem_write;
    mem_read_nx  = mem_read;
    addr_nx      = mem_address;
    wdata_nx     = mem_data_in;
    pay_nx       = pay_q;
    wb_valid_nx  = wb_valid;
    err_nx       = op_err;

    case (state)
      ACCESS: begin
        // The store strobe lasts only for the first access cycle.
        mem_write_nx = 1'b0;
        if (cnt == '0) begin
          mem_read_nx = 1'b0;
          if (ld_q) pay_nx.data = mem_data_out;
          wb_valid_nx = 1'b1;
          state_nx    = HOLD;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (wb_ready) begin
          wb_valid_nx = 1'b0;
          state_nx    = IDLE;
        end
      end
      default: ;
    endcase

    // An accept only happens in IDLE or in HOLD with WB draining. It
    // overrides the HOLD->IDLE path, so back-to-back operations have no bubble.
    if (accept) begin
      pay_nx.rd   = ex_rd;
      pay_nx.data = ex_result;
      if (ex_is_load & ex_is_store) err_nx = 1'b1;
      if (mem_op & ~oob) begin
        state_nx     = ACCESS;
        cnt_nx       = CW'(MEM_LAT - 1);
        ld_nx        = ~is_store;
        mem_read_nx  = ~is_store;
        mem_write_nx = is_store;
        addr_nx      = ex_addr;
        wdata_nx     = ex_wdata;
        pay_nx.we    = ex_rd_we & ~is_store;
        wb_valid_nx  = 1'b0;
      end else if (mem_op) begin
        // Out-of-range access: nothing is issued to memory. Complete at once.
        state_nx    = HOLD;
        pay_nx.data = '0;
        pay_nx.we   = 1'b0;
        err_nx      = 1'b1;
        wb_valid_nx = 1'b1;
      end else begin
        state_nx    = HOLD;
        pay_nx.we   = ex_rd_we;
        wb_valid_nx = 1'b1;
      end
    end
  end

  // An async reset drops mem_write at once, so an aborted store cannot
  // strobe again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      ld_q        <= 1'b0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      pay_q       <= '0;
      wb_valid    <= 1'b0;
      op_err      <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      ld_q        <= ld_nx;
      mem_write   <= mem_write_nx;
      mem_read    <= mem_read_nx;
      mem_address <= addr_nx;
      mem_data_in <= wdata_nx;
      pay_q       <= pay_nx;
      wb_valid    <= wb_valid_nx;
      op_err      <= err_nx;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
`ifndef A_BITS
`define A_BITS 8
`endif
`ifndef D_BITS
`define D_BITS 8
`endif
`ifndef MEMSIZE
`define MEMSIZE 128
`endif

module tb_mem_access_stage;
  localparam int AW  = `A_BITS;
  localparam int DW  = `D_BITS;
  localparam int RW  = 3;
  localparam int LAT = 3;
  localparam int MSZ = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  logic ex_valid, ex_ready, ex_is_load, ex_is_store, ex_rd_we;
  logic [AW-1:0] ex_addr;
  logic [DW-1:0] ex_wdata, ex_result;
  logic [RW-1:0] ex_rd;
  logic mem_write, mem_read;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic wb_valid, wb_ready, wb_we, op_err;
  logic [DW-1:0] wb_data;
  logic [RW-1:0] wb_rd;

  always #5 clk = ~clk;

  mem_access_stage #(.A_BITS(AW), .D_BITS(DW), .R_BITS(RW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_result(ex_result),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we), .op_err(op_err)
  );

  // Physical memory, written only when the DUT strobes mem_write.
  logic [DW-1:0] phys [0:MSZ-1];
  assign mem_data_out = phys[mem_address];

  function automatic logic [DW-1:0] init_val(int a);
    return DW'(a * 7 + 3);
  endfunction

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model (transaction + timestamps) ----------
  logic [DW-1:0] ref_mem [0:MSZ-1];
  int  cyc;                        // period index, bumped at each clock edge
  bit  pend;                       // an op is in the stage and not yet taken by WB
  bit  p_mem, p_ld, p_st, p_chkd, p_we;
  int  p_acc, p_vcyc;              // first access period, first valid period
  logic [DW-1:0] p_data, p_wd;
  logic [AW-1:0] p_addr;
  logic [RW-1:0] p_rd;
  bit  m_err, m_acc;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  function automatic bit e_valid();  return pend && cyc >= p_vcyc; endfunction
  function automatic bit e_ready();  return !pend || (e_valid() && wb_ready); endfunction
  function automatic bit e_read();   return pend && p_mem && p_ld && cyc >= p_acc && cyc < p_vcyc; endfunction
  function automatic bit e_write();  return pend && p_mem && p_st && cyc == p_acc; endfunction

  task automatic model_reset();
    pend = 0; m_err = 0; m_acc = 0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic model_edge();
    bit v, r, oob, mop;
    m_acc = 0;
    if (!rst_n) begin cyc++; return; end
    if (pend && p_mem && p_st && cyc == p_acc) ref_mem[p_addr] = p_wd;
    v = e_valid(); r = e_ready();
    if (v && wb_ready) pend = 0;
    if (ex_valid && r) begin
      m_acc = 1; pend = 1; p_rd = ex_rd;
      mop = ex_is_load || ex_is_store;
`ifdef MEM_BOUNDS_EN
      oob = mop && (int'(ex_addr) >= `MEMSIZE);
`else
      oob = 0;
`endif
      if (ex_is_load && ex_is_store) m_err = 1;
      p_st = ex_is_store; p_ld = ex_is_load && !ex_is_store;
      if (mop && !oob) begin
        p_mem = 1; p_acc = cyc + 1; p_vcyc = cyc + 1 + LAT;
        p_addr = ex_addr; p_wd = ex_wdata;
        m_addr = ex_addr; m_wdata = ex_wdata;
        p_we = ex_rd_we && !p_st; p_chkd = p_ld;
        p_data = p_ld ? ref_mem[ex_addr] : '0;
      end else if (oob) begin
        p_mem = 0; p_vcyc = cyc + 1; p_data = '0; p_we = 0; p_chkd = 1; m_err = 1;
      end else begin
        p_mem = 0; p_vcyc = cyc + 1; p_data = ex_result; p_we = ex_rd_we; p_chkd = 1;
      end
    end
    cyc++;
  endtask

  // Single compare process, mid-period.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ex_ready", ex_ready, e_ready());
      chk("wb_valid", wb_valid, e_valid());
      chk("mem_read", mem_read, e_read());
      chk("mem_write", mem_write, e_write());
      chk("mem_address", mem_address, m_addr);
      chk("mem_data_in", mem_data_in, m_wdata);
      chk("op_err", op_err, m_err);
      if (!rst_n) begin
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_we", wb_we, 0);
      end else if (e_valid()) begin
        chk("wb_rd", wb_rd, p_rd);
        chk("wb_we", wb_we, p_we);
        if (p_chkd) chk("wb_data", wb_data, p_data);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    logic w; logic [AW-1:0] a; logic [DW-1:0] d;
    #1; w = mem_write; a = mem_address; d = mem_data_in;
    @(posedge clk);
    if (w) phys[a] = d;
    model_edge();
    #2;
  endtask

  task automatic set_op(bit v, bit ld, bit st, int a, int wd, int res, int rd, bit we);
    ex_valid = v; ex_is_load = ld; ex_is_store = st;
    ex_addr = AW'(a); ex_wdata = DW'(wd); ex_result = DW'(res);
    ex_rd = RW'(rd); ex_rd_we = we;
  endtask

  task automatic send(bit ld, bit st, int a, int wd, int res, int rd, bit we);
    set_op(1, ld, st, a, wd, res, rd, we);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (m_acc) break;
    end
    if (!m_acc) chk("send_timeout", 0, 1);
    ex_valid = 0;
  endtask

  task automatic idle(int n);
    ex_valid = 0; wb_ready = 1;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its end, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MSZ; i++) begin phys[i] = init_val(i); ref_mem[i] = init_val(i); end
    cyc = 0; p_mem = 0; p_ld = 0; p_st = 0; p_chkd = 0; p_we = 0;
    p_acc = 0; p_vcyc = 0; p_data = '0; p_wd = '0; p_addr = '0; p_rd = '0;
    set_op(0, 0, 0, 0, 0, 0, 0, 0);
    wb_ready = 1; rst_n = 0;
    model_reset();
    chk_en = 1;
    tick(); tick();
    @(negedge clk);
    chk("reset_wb_valid", wb_valid, 0);
    chk("reset_ex_ready", ex_ready, 1);
    rst_n = 1;
    idle(2);

    // Store 5 <- A5: one-cycle strobe with stable address/data.
    send(0, 1, 5, 8'hA5, 0, 1, 1);
    @(negedge clk);
    chk("st_strobe", mem_write, 1);
    chk("st_addr", mem_address, 5);
    chk("st_data", mem_data_in, 8'hA5);
    tick();
    @(negedge clk);
    chk("st_strobe_off", mem_write, 0);
    chk("st_addr_hold", mem_address, 5);

    // Load 5: read enable held LAT cycles, then data appears.
    send(1, 0, 5, 0, 0, 3, 1);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      chk("ld_busy_valid", wb_valid, 0);
      chk("ld_read_en", mem_read, 1);
      chk("ld_ex_ready", ex_ready, 0);
      tick();
    end
    @(negedge clk);
    chk("ld_valid", wb_valid, 1);
    chk("ld_data", wb_data, 8'hA5);
    chk("ld_we", wb_we, 1);
    idle(2);

    // Three back-to-back ALU results, no bubbles.
    set_op(1, 0, 0, 0, 0, 1, 1, 1);
    tick();
    set_op(1, 0, 0, 0, 0, 2, 2, 1);
    @(negedge clk); chk("b2b_1", wb_data, 1); chk("b2b_v1", wb_valid, 1);
    tick();
    set_op(1, 0, 0, 0, 0, 3, 3, 1);
    @(negedge clk); chk("b2b_2", wb_data, 2); chk("b2b_v2", wb_valid, 1);
    tick();
    ex_valid = 0;
    @(negedge clk); chk("b2b_3", wb_data, 3); chk("b2b_v3", wb_valid, 1);
    tick();
    @(negedge clk); chk("b2b_end", wb_valid, 0);

    // WB stall: payload held, next op waits for wb_ready.
    wb_ready = 0;
    send(0, 0, 0, 0, 9, 4, 1);
    set_op(1, 0, 0, 0, 0, 10, 5, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_data", wb_data, 9);
      chk("stall_rd", wb_rd, 4);
      chk("stall_ready", ex_ready, 0);
      tick();
    end
    wb_ready = 1;
    @(negedge clk); chk("stall_release", ex_ready, 1);
    tick();
    ex_valid = 0;
    @(negedge clk); chk("stall_next", wb_data, 10); chk("stall_next_rd", wb_rd, 5);
    idle(2);

    // Load+store together: executed as store, sticky error.
    send(1, 1, 7, 8'h3C, 0, 2, 1);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      chk("ls_strobe", mem_write, (k == 0) ? 1 : 0);
      chk("ls_no_read", mem_read, 0);
      tick();
    end
    @(negedge clk);
    chk("ls_we", wb_we, 0);
    chk("ls_err", op_err, 1);
    idle(3);
    @(negedge clk); chk("ls_err_sticky", op_err, 1);
    send(1, 0, 7, 0, 0, 6, 1);
    for (int k = 0; k < LAT; k++) tick();
    @(negedge clk); chk("ls_readback", wb_data, 8'h3C);
    idle(2);

    // Reset in the first access cycle of a store aborts it.
    send(0, 1, 9, 8'h55, 0, 1, 0);
    #1 chk("rst_pre_strobe", mem_write, 1);
    rst_n = 0; model_reset();
    #1 chk("rst_strobe_drop", mem_write, 0);
    chk("rst_err_clear", op_err, 0);
    tick(); tick();
    rst_n = 1;
    tick();
    @(negedge clk); chk("rst_idle", ex_ready, 1);
    send(1, 0, 9, 0, 0, 1, 1);
    for (int k = 0; k < LAT; k++) tick();
    @(negedge clk); chk("rst_no_write", wb_data, 8'h42);
    idle(2);

`ifdef MEM_BOUNDS_EN
    send(1, 0, `MEMSIZE, 0, 0, 2, 1);
    @(negedge clk);
    chk("oob_no_read", mem_read, 0);
    chk("oob_valid", wb_valid, 1);
    chk("oob_data", wb_data, 0);
    chk("oob_err", op_err, 1);
    idle(2);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 399) == 0) begin rst_n = 0; model_reset(); end
      r = $urandom_range(0, 19);
      set_op($urandom_range(0, 9) < 7,
             (r < 8) || (r == 19), (r >= 8 && r < 13) || (r == 19),
             ($urandom_range(0, 7) == 0) ? $urandom_range(0, MSZ - 1) : $urandom_range(0, 15),
             $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 7), $urandom_range(0, 1) == 1);
      wb_ready = $urandom_range(0, 9) < 7;
      tick();
    end
    rst_n = 1;
    idle(LAT + 4);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
